// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      STEP  = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int unsigned NIB_W  = 4;
   localparam int unsigned PROD_W = 8;
   localparam int unsigned OP_W   = 8;
   localparam int unsigned RES_W  = 16;

   // Left shift applied to the partial product of each step:
   // lo*lo, lo*hi, hi*lo, hi*hi.
   localparam logic [3:0] STEP_SHIFT [4] = '{4'd0, 4'd4, 4'd4, 4'd8};

endpackage

// File: rtl/mult4_core.sv
// 4x4 -> 8 unsigned combinational product unit.
module mult4_core
   import mult_pkg::*;
(
   input  logic [NIB_W-1:0]  i_a,
   input  logic [NIB_W-1:0]  i_b,
   output logic [PROD_W-1:0] o_p
);

   assign o_p = PROD_W'(i_a) * PROD_W'(i_b);

endmodule

// File: rtl/mult8_seq_accum.sv
// Sequential 8x8 unsigned multiplier: one shared 4x4 product unit, four
// nibble-pair steps, 16-bit accumulator, valid/ready on both sides.
// PIPE_MUL=1 registers the product-unit output (adds a FLUSH cycle).
// Optional macro MULT8_ZERO_SKIP_EN: a zero operand jumps straight to DONE.
module mult8_seq_accum
   import mult_pkg::*;
#(
   parameter int unsigned PIPE_MUL = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  a,
   input  logic [OP_W-1:0]  b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [RES_W-1:0] p,
   output logic             busy
);

   localparam bit PIPE = (PIPE_MUL != 0);

   state_t             r_state;
   logic [1:0]         r_step;
   logic [OP_W-1:0]    r_a;
   logic [OP_W-1:0]    r_b;
   logic [RES_W-1:0]   r_acc;
   logic [RES_W-1:0]   r_p;
   logic               r_out_valid;

   logic [NIB_W-1:0]   w_nib_a;
   logic [NIB_W-1:0]   w_nib_b;
   logic [PROD_W-1:0]  w_prod;
   logic [PROD_W-1:0]  w_add_prod;
   logic [1:0]         w_add_step;
   logic [RES_W-1:0]   w_term;
   logic [RES_W-1:0]   w_acc_sum;

   // Step bit 1 selects the a nibble, bit 0 the b nibble.
   assign w_nib_a = r_step[1] ? r_a[7:4] : r_a[3:0];
   assign w_nib_b = r_step[0] ? r_b[7:4] : r_b[3:0];

   mult4_core u_core (
      .i_a (w_nib_a),
      .i_b (w_nib_b),
      .o_p (w_prod)
   );

   // With the pipeline register, the product added now belongs to the
   // previous step, so its shift must travel with it.
   if (PIPE) begin : g_pipe
      logic [PROD_W-1:0] r_prod;
      logic [1:0]        r_pstep;

      // Register the product-unit output and the step it came from.
      always_ff @(posedge clk) begin
         if (rst) begin
            r_prod  <= '0;
            r_pstep <= '0;
         end else begin
            r_prod  <= w_prod;
            r_pstep <= r_step;
         end
      end

      assign w_add_prod = r_prod;
      assign w_add_step = r_pstep;
   end else begin : g_nopipe
      assign w_add_prod = w_prod;
      assign w_add_step = r_step;
   end

   assign w_term    = {{(RES_W-PROD_W){1'b0}}, w_add_prod} << STEP_SHIFT[w_add_step];
   assign w_acc_sum = r_acc + w_term;

   assign in_ready  = (r_state == IDLE) && !rst;
   assign busy      = (r_state != IDLE);
   assign out_valid = r_out_valid;
   assign p         = r_p;

   // Control FSM, accumulator and registered result.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_step      <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_acc       <= '0;
         r_p         <= '0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  r_a    <= a;
                  r_b    <= b;
                  r_acc  <= '0;
                  r_step <= '0;
`ifdef MULT8_ZERO_SKIP_EN
                  if ((a == '0) || (b == '0)) begin
                     r_p         <= '0;
                     r_out_valid <= 1'b1;
                     r_state     <= DONE;
                  end else begin
                     r_state <= STEP;
                  end
`else
                  r_state <= STEP;
`endif
               end
            end
            STEP: begin
               // Pipelined: nothing valid to add until step 1.
               if (!PIPE || (r_step != 2'd0)) begin
                  r_acc <= w_acc_sum;
               end
               r_step <= r_step + 2'd1;
               if (r_step == 2'd3) begin
                  if (PIPE) begin
                     r_state <= FLUSH;
                  end else begin
                     r_p         <= w_acc_sum;
                     r_out_valid <= 1'b1;
                     r_state     <= DONE;
                  end
               end
            end
            FLUSH: begin
               r_acc       <= w_acc_sum;
               r_p         <= w_acc_sum;
               r_out_valid <= 1'b1;
               r_state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult8_seq_accum.sv
// Directed and randomized checks for mult8_seq_accum (PIPE_MUL=0).
module tb_mult8_seq_accum;

   localparam int unsigned PIPE_MUL = 0;
   localparam int          LAT      = 5 + int'(PIPE_MUL);
`ifdef MULT8_ZERO_SKIP_EN
   localparam bit ZSKIP = 1'b1;
`else
   localparam bit ZSKIP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  a = '0;
   logic [7:0]  b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] p;
   logic        busy;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   mult8_seq_accum #(.PIPE_MUL(PIPE_MUL)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p         (p),
      .busy      (busy)
   );

   typedef struct {
      logic [7:0]  va;
      logic [7:0]  vb;
      logic [15:0] exp_p;
   } vec_t;

   vec_t vecs [12];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Issue one operand pair and wait for out_valid; leaves the DUT in DONE.
   task automatic do_txn(input logic [7:0] ta, input logic [7:0] tb,
                         output logic [15:0] got, output int lat);
      int w;
      w = 0;
      while (!in_ready && w < 40) begin
         tick();
         w++;
      end
      a = ta;
      b = tb;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      a = 8'h5C;
      b = 8'hC5;
      lat = 1;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      got = p;
   endtask

   function automatic int exp_lat(input logic [7:0] ta, input logic [7:0] tb);
      if (ZSKIP && (ta == 8'h00 || tb == 8'h00)) return 1;
      return LAT;
   endfunction

   initial begin
      logic [15:0] got;
      logic [15:0] held;
      int          lat;
      int          bad;
      int          dup;
      int          k;

      vecs[0]  = '{8'hFF, 8'hFF, 16'hFE01};
      vecs[1]  = '{8'h12, 8'h34, 16'h03A8};
      vecs[2]  = '{8'h0F, 8'h10, 16'h00F0};
      vecs[3]  = '{8'hA5, 8'h5A, 16'h3A02};
      vecs[4]  = '{8'h80, 8'h80, 16'h4000};
      vecs[5]  = '{8'h03, 8'h05, 16'h000F};
      vecs[6]  = '{8'h00, 8'h77, 16'h0000};
      vecs[7]  = '{8'h77, 8'h00, 16'h0000};
      vecs[8]  = '{8'h01, 8'hFF, 16'h00FF};
      vecs[9]  = '{8'hFF, 8'h01, 16'h00FF};
      vecs[10] = '{8'h10, 8'h10, 16'h0100};
      vecs[11] = '{8'hAB, 8'hCD, 16'h88EF};

      // Reset state
      rst = 1'b1;
      tick();
      tick();
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_p", p, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      #1;
      check("idle_in_ready", in_ready, 1);

      // Table: value, latency, single-cycle out_valid pulse
      out_ready = 1'b1;
      foreach (vecs[i]) begin
         do_txn(vecs[i].va, vecs[i].vb, got, lat);
         check($sformatf("vec%0d_p", i), got, vecs[i].exp_p);
         check($sformatf("vec%0d_lat", i), lat, exp_lat(vecs[i].va, vecs[i].vb));
         tick();
         check($sformatf("vec%0d_pulse", i), out_valid, 0);
      end

      // Back-pressure: result held for 10 cycles
      out_ready = 1'b0;
      do_txn(8'h12, 8'h34, got, lat);
      check("bp_p", got, 16'h03A8);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (!out_valid || p !== 16'h03A8 || in_ready || !busy) bad++;
      end
      check("bp_stable", bad, 0);
      out_ready = 1'b1;
      tick();
      check("bp_release_valid", out_valid, 0);
      check("bp_release_busy", busy, 0);
      check("bp_release_ready", in_ready, 1);

      // Back-to-back with in_valid held high
      a = 8'h0F;
      b = 8'h10;
      in_valid = 1'b1;
      tick();
      a = 8'hA5;
      b = 8'h5A;
      lat = 1;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      check("b2b_first_p", p, 16'h00F0);
      check("b2b_first_lat", lat, LAT);
      tick();
      check("b2b_gap_busy", busy, 0);
      check("b2b_gap_valid", out_valid, 0);
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      check("b2b_second_p", p, 16'h3A02);
      check("b2b_second_lat", lat, LAT);
      tick();

      // Reset during step 2 discards the operation
      a = 8'h80;
      b = 8'h80;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_p", p, 0);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (out_valid) bad++;
      end
      check("mid_rst_no_valid", bad, 0);
      do_txn(8'h03, 8'h05, got, lat);
      check("post_rst_p", got, 16'h000F);
      check("post_rst_lat", lat, LAT);
      tick();

      // Random operands with random out_ready
      dup = 0;
      for (int i = 0; i < 2000; i++) begin
         logic [7:0] ra;
         logic [7:0] rb;
         ra = 8'($urandom);
         rb = 8'($urandom);
         k = 0;
         while (!in_ready && k < 40) begin
            out_ready = 1'b1;
            tick();
            k++;
         end
         a = ra;
         b = rb;
         in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         a = 8'($urandom);
         b = 8'($urandom);
         k = 0;
         got = 16'hXXXX;
         held = 16'h0000;
         while (k < 100) begin
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid) held = p;
            if (out_valid && out_ready) begin
               got = p;
               tick();
               if (out_valid) dup++;
               break;
            end
            tick();
            k++;
            if (out_valid && held != 16'h0000 && p !== held) dup++;
         end
         check($sformatf("rand%0d_p", i), got, 16'(ra) * 16'(rb));
      end
      check("rand_dup_or_unstable", dup, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
